// File: rtl/decode_queue.sv
// RV32I decode queue: decodes one instruction per cycle into a DEPTH-entry
// circular FIFO and presents the oldest decoded record to rename/dispatch.
module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc_in,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic             ready_out,
    output logic             valid_out,
    output logic [31:0]      pc_out,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [31:0]      imm,
    output logic [2:0]       alu_op,
    output logic [6:0]       opcode,
    output logic             fu_mem,
    output logic             fu_alu,
    output logic             illegal,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Entry storage, one array per decoded field
    logic [31:0] r_pc      [DEPTH];
    logic [4:0]  r_rs1     [DEPTH];
    logic [4:0]  r_rs2     [DEPTH];
    logic [4:0]  r_rd      [DEPTH];
    logic [31:0] r_imm     [DEPTH];
    logic [2:0]  r_alu_op  [DEPTH];
    logic [6:0]  r_opcode  [DEPTH];
    logic        r_fu_mem  [DEPTH];
    logic        r_fu_alu  [DEPTH];
    logic        r_illegal [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [6:0]  w_opc;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic [2:0]  w_alu_op;
    logic        w_fu_mem;
    logic        w_fu_alu;
    logic        w_illegal;
    logic        w_enq;
    logic        w_deq;

    assign w_opc = instr[6:0];

    // Combinational decode of the incoming instruction
    always_comb begin
        w_rd      = instr[11:7];
        w_imm     = 32'h0;
        w_alu_op  = 3'h0;
        w_fu_mem  = 1'b0;
        w_fu_alu  = 1'b0;
        w_illegal = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_alu_op = instr[14:12];
                w_fu_alu = 1'b1;
            end
            OPC_OP_IMM: begin
                w_imm    = {{20{instr[31]}}, instr[31:20]};
                w_alu_op = instr[14:12];
                w_fu_alu = 1'b1;
            end
            OPC_LOAD: begin
                w_imm    = {{20{instr[31]}}, instr[31:20]};
                w_fu_mem = 1'b1;
            end
            OPC_STORE: begin
                w_rd     = 5'h0;
                w_imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                w_fu_mem = 1'b1;
            end
            OPC_BRANCH: begin
                w_rd  = 5'h0;
                w_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            OPC_JAL: begin
                w_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                w_imm = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_LUI, OPC_AUIPC: begin
                w_imm    = {instr[31:12], 12'h0};
                w_fu_alu = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Handshake state depends only on the registered occupancy
    assign ready_in  = (r_count < CNT_W'(DEPTH));
    assign valid_out = (r_count != '0);
    assign w_enq     = valid_in && ready_in;
    assign w_deq     = valid_out && ready_out;

    // Pointers and occupancy; flush and reset both empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry storage: cleared on reset, written only on a non-flushed enqueue
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_pc[i]      <= 32'h0;
                r_rs1[i]     <= 5'h0;
                r_rs2[i]     <= 5'h0;
                r_rd[i]      <= 5'h0;
                r_imm[i]     <= 32'h0;
                r_alu_op[i]  <= 3'h0;
                r_opcode[i]  <= 7'h0;
                r_fu_mem[i]  <= 1'b0;
                r_fu_alu[i]  <= 1'b0;
                r_illegal[i] <= 1'b0;
            end
        end else if (w_enq && !flush) begin
            r_pc[r_wr_ptr]      <= pc_in;
            r_rs1[r_wr_ptr]     <= instr[19:15];
            r_rs2[r_wr_ptr]     <= instr[24:20];
            r_rd[r_wr_ptr]      <= w_rd;
            r_imm[r_wr_ptr]     <= w_imm;
            r_alu_op[r_wr_ptr]  <= w_alu_op;
            r_opcode[r_wr_ptr]  <= w_opc;
            r_fu_mem[r_wr_ptr]  <= w_fu_mem;
            r_fu_alu[r_wr_ptr]  <= w_fu_alu;
            r_illegal[r_wr_ptr] <= w_illegal;
        end
    end

    assign pc_out  = r_pc[r_rd_ptr];
    assign rs1     = r_rs1[r_rd_ptr];
    assign rs2     = r_rs2[r_rd_ptr];
    assign rd      = r_rd[r_rd_ptr];
    assign imm     = r_imm[r_rd_ptr];
    assign alu_op  = r_alu_op[r_rd_ptr];
    assign opcode  = r_opcode[r_rd_ptr];
    assign fu_mem  = r_fu_mem[r_rd_ptr];
    assign fu_alu  = r_fu_alu[r_rd_ptr];
    assign illegal = r_illegal[r_rd_ptr];
    assign count   = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected decoded records are queued at
// enqueue and compared against the head whenever valid_out is high.
module tb_decode_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [31:0]      instr;
    logic [31:0]      pc_in;
    logic             valid_in;
    logic             ready_in;
    logic             ready_out;
    logic             valid_out;
    logic [31:0]      pc_out;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [2:0]       alu_op;
    logic [6:0]       opcode;
    logic             fu_mem;
    logic             fu_alu;
    logic             illegal;
    logic [CNT_W-1:0] count;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .instr(instr), .pc_in(pc_in),
        .valid_in(valid_in), .ready_in(ready_in), .ready_out(ready_out),
        .valid_out(valid_out), .pc_out(pc_out), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .alu_op(alu_op), .opcode(opcode), .fu_mem(fu_mem),
        .fu_alu(fu_alu), .illegal(illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  alu_op;
        logic [6:0]  opcode;
        logic        fu_mem;
        logic        fu_alu;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode built from arithmetic shifts and masks
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic signed [31:0] s;
        logic [6:0] op;
        s = $signed(ins);
        op = ins[6:0];
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.opcode = op; e.imm = 32'h0; e.alu_op = 3'h0;
        e.fu_mem = (op == 7'h03) || (op == 7'h23);
        e.fu_alu = (op == 7'h33) || (op == 7'h13) || (op == 7'h37) || (op == 7'h17);
        e.illegal = !(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17});
        if (op == 7'h33 || op == 7'h13) e.alu_op = ins[14:12];
        if (op == 7'h23 || op == 7'h63) e.rd = 5'h0;
        if (op == 7'h13 || op == 7'h03 || op == 7'h67)
            e.imm = 32'(s >>> 20);
        else if (op == 7'h23)
            e.imm = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(ins[11:7]);
        else if (op == 7'h63)
            e.imm = (32'(s >>> 19) & 32'hFFFF_F000) | (32'(ins[7]) << 11)
                  | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        else if (op == 7'h37 || op == 7'h17)
            e.imm = ins & 32'hFFFF_F000;
        else if (op == 7'h6F)
            e.imm = (32'(s >>> 11) & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                  | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        return e;
    endfunction

    task automatic cmp_head(input exp_t e);
        check("pc_out",  pc_out,         e.pc);
        check("rs1",     32'(rs1),       32'(e.rs1));
        check("rs2",     32'(rs2),       32'(e.rs2));
        check("rd",      32'(rd),        32'(e.rd));
        check("imm",     imm,            e.imm);
        check("alu_op",  32'(alu_op),    32'(e.alu_op));
        check("opcode",  32'(opcode),    32'(e.opcode));
        check("fu_mem",  32'(fu_mem),    32'(e.fu_mem));
        check("fu_alu",  32'(fu_alu),    32'(e.fu_alu));
        check("illegal", 32'(illegal),   32'(e.illegal));
    endtask

    // One clock: drive at negedge, check head and handshake, update scoreboard
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        logic acc_in;
        logic acc_out;
        valid_in = v; instr = ins; pc_in = pc; ready_out = rdy; flush = fl;
        #1;
        check("count",     32'(count),     32'(q.size()));
        check("valid_out", 32'(valid_out), 32'(q.size() != 0));
        check("ready_in",  32'(ready_in),  32'(q.size() < DEPTH));
        if (valid_out) begin
            if (q.size() == 0) check("head_unexpected", 32'(valid_out), 32'h0);
            else cmp_head(q[0]);
        end
        acc_in  = v && (q.size() < DEPTH);
        acc_out = rdy && (q.size() != 0);
        if (fl) begin
            q.delete();
        end else begin
            if (acc_out) void'(q.pop_front());
            if (acc_in) q.push_back(model(ins, pc));
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) idle(1'b1);
        check("drain_empty", 32'(q.size()), 32'h0);
        idle(1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_out = 1'b0;
        instr = 32'h0; pc_in = 32'h0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        q.delete();
        #1;
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_ready_in",  32'(ready_in),  32'h1);
        check("rst_count",     32'(count),     32'h0);
        check("rst_pc_out",    pc_out,         32'h0);
        check("rst_imm",       imm,            32'h0);
        check("rst_fields",    {7'h0, rs1, rs2, rd, alu_op, opcode},   32'h0);
        check("rst_flags",     {29'h0, fu_mem, fu_alu, illegal},       32'h0);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        r = $urandom();
        r[6:0] = ops[$urandom_range(0, 9)];
        return r;
    endfunction

    initial begin
        do_reset();

        // ADDI x1,x0,5 accepted immediately
        cycle(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
        check("addi_valid",  32'(valid_out), 32'h1);
        check("addi_rd",     32'(rd),        32'h1);
        check("addi_rs1",    32'(rs1),       32'h0);
        check("addi_imm",    imm,            32'h5);
        check("addi_opcode", 32'(opcode),    32'h13);
        check("addi_fu_alu", 32'(fu_alu),    32'h1);
        check("addi_pc",     pc_out,         32'h100);
        idle(1'b1);
        check("addi_count0", 32'(count),     32'h0);

        // SW then BEQ -4
        cycle(1'b1, 32'h0020_A423, 32'h104, 1'b1, 1'b0);
        check("sw_rs1",    32'(rs1),    32'h1);
        check("sw_rs2",    32'(rs2),    32'h2);
        check("sw_rd",     32'(rd),     32'h0);
        check("sw_imm",    imm,         32'h8);
        check("sw_fu_mem", 32'(fu_mem), 32'h1);
        check("sw_fu_alu", 32'(fu_alu), 32'h0);
        cycle(1'b1, 32'hFE00_0EE3, 32'h108, 1'b1, 1'b0);
        check("beq_imm",   imm,         32'hFFFF_FFFC);
        check("beq_rd",    32'(rd),     32'h0);
        drain();

        // Fill to full with five back-to-back valids, fifth refused
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_0013 | (32'(i) << 20), 32'(4 * i), 1'b0, 1'b0);
        check("full_count",    32'(count),    32'h4);
        check("full_ready_in", 32'(ready_in), 32'h0);
        // Release with continuous refill to exercise pointer wrap
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_instr(), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
        drain();

        // Simultaneous enqueue and dequeue at count 2
        cycle(1'b1, 32'h0010_8113, 32'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_8193, 32'h304, 1'b0, 1'b0);
        cycle(1'b1, 32'h0030_8213, 32'h308, 1'b1, 1'b0);
        check("enq_deq_count", 32'(count), 32'h2);
        check("enq_deq_head",  pc_out,     32'h304);
        drain();

        // Flush at count 3 together with a valid instruction
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_instr(), 32'h400 + 32'(4 * i), 1'b0, 1'b0);
        check("pre_flush_count", 32'(count), 32'h3);
        cycle(1'b1, 32'h0050_0093, 32'h999, 1'b0, 1'b1);
        check("flush_count", 32'(count),     32'h0);
        check("flush_valid", 32'(valid_out), 32'h0);
        idle(1'b1);
        check("flush_stays_empty", 32'(valid_out), 32'h0);
        cycle(1'b1, 32'h0000_0037, 32'h500, 1'b0, 1'b0);
        check("post_flush_pc", pc_out, 32'h500);
        drain();

        // Illegal opcode is still queued and delivered
        cycle(1'b1, 32'hFFFF_FFFF, 32'h600, 1'b0, 1'b0);
        check("ill_flag",   32'(illegal), 32'h1);
        check("ill_fu_alu", 32'(fu_alu),  32'h0);
        check("ill_fu_mem", 32'(fu_mem),  32'h0);
        check("ill_imm",    imm,          32'h0);
        drain();

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 32'h1000 + 32'(4 * i),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        drain();

        // Reset in the middle of a stream discards everything
        for (int i = 0; i < 2; i++) cycle(1'b1, rand_instr(), 32'h700 + 32'(4 * i), 1'b0, 1'b0);
        do_reset();
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
